vga_timing_core: RTL
====================

Name: vga_timing_core

Overview:
- Raster timing generator that sits directly upstream of the glyph/rain renderer.
- Produces the pixel coordinates, sync pulses and display-enable that the renderer consumes.
- Also produces frame-synchronous strobes and a frame counter. Downstream logic then advances animation in the pixel clock domain, so it never has to clock a register off vsync.
- Default timing is 1024x768@60 with a 65 MHz pixel clock: 64 text rows of 12 lines, 128 glyph columns of 8 pixels.

Parameters:
- H_DISPLAY, 1024, visible pixels per line
- H_FRONT, 24, horizontal front porch in pixels
- H_SYNC, 136, hsync pulse width in pixels
- H_BACK, 160, horizontal back porch in pixels
- V_DISPLAY, 768, visible lines per frame
- V_FRONT, 3, vertical front porch in lines
- V_SYNC, 6, vsync pulse width in lines
- V_BACK, 29, vertical back porch in lines
- H_SYNC_POL, 0, active level of hsync (0 = active-low)
- V_SYNC_POL, 0, active level of vsync (0 = active-low)

Ports:
- clk, input, 1, pixel clock
- reset, input, 1, asynchronous active-high reset
- ce, input, 1, pixel advance enable; when low, all state holds
- hpos, output, 11, horizontal pixel counter
- vpos, output, 10, vertical line counter
- hsync, output, 1, horizontal sync at H_SYNC_POL level when active
- vsync, output, 1, vertical sync at V_SYNC_POL level when active
- display_on, output, 1, high inside the visible area
- line_start, output, 1, one-cycle strobe at hpos==0
- vblank_start, output, 1, one-cycle strobe at hpos==0, vpos==V_DISPLAY
- frame_count, output, 10, frames completed since reset; wraps

Behaviour:
- Derived constants:
  - H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK (default 1344).
  - V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK (default 806).
- Elaboration: generate an error if H_TOTAL > 2048 or V_TOTAL > 1024.
- All outputs are registered; no combinational path from any input to any output.
- Async reset, effective immediately on assertion, sets:
  - hpos = 0, vpos = 0, frame_count = 0;
  - hsync = !H_SYNC_POL, vsync = !V_SYNC_POL;
  - display_on = 0, line_start = 0, vblank_start = 0.
- Counting, on each clk edge with ce=1:
  - hpos increments; hpos == H_TOTAL-1 wraps to 0.
  - On that wrap vpos increments; vpos == V_TOTAL-1 wraps to 0.
- With ce=0 every register holds, and the strobes hold their current value. Strobes are therefore one ce-qualified cycle long. Consumers gate strobes with ce.
- The sync and enable flags are registered from the next counter value, so they always align with the hpos/vpos presented in the same cycle:
  - hsync active iff H_DISPLAY+H_FRONT <= hpos < H_DISPLAY+H_FRONT+H_SYNC.
  - vsync active iff V_DISPLAY+V_FRONT <= vpos < V_DISPLAY+V_FRONT+V_SYNC. vsync changes only at hpos==0.
  - display_on = (hpos < H_DISPLAY) && (vpos < V_DISPLAY).
  - line_start = (hpos == 0).
  - vblank_start = (hpos == 0) && (vpos == V_DISPLAY).
- Post-reset exception:
  - While reset is high, and in the reset state at (0,0), display_on and line_start read 0.
  - The first ce edge after release moves to hpos=1.
  - Pixel (0,0) of the first frame is therefore blanked. The alignment invariant holds from that edge onward.
- frame_count:
  - Increments by 1 on the same edge that asserts vblank_start, so the new value is visible in the strobe cycle.
  - Wraps 1023 -> 0.
  - Consumers needing a saturating "first pass complete" flag derive it from the wrap.
- Reset mid-frame: all state returns to the reset values asynchronously; there is no partial-line completion.
- No other state is held. There is no sync-polarity change at runtime; parameters are static.

Test Plan:
- Reset/release: assert reset mid-line (hpos=500, vpos=300) -> all outputs take reset values within the same cycle. After release with ce=1, first edge gives hpos=1, vpos=0, display_on=1, hsync=1, vsync=1.
- Horizontal timing, defaults: display_on falls when hpos goes 1023->1024. hsync goes low at hpos=1048, stays low through hpos=1183, returns high at 1184. hpos wraps 1343->0 with vpos+1 and line_start=1 for exactly that cycle.
- Vertical timing: vsync low exactly for vpos 771..776, with edges coincident with hpos==0. display_on stays 0 for all hpos while vpos is 768..805. vpos wraps 805->0.
- Frame strobe/counter: run 3 frames -> vblank_start pulses once per frame at (0,768), with frame_count 1,2,3 in the strobe cycles. Preload by forcing 1023 -> next strobe shows 0.
- ce gating: drive ce=1,0,0,1 repeating around hpos=1047..1049 and at (0,768) -> counters advance only on ce=1. hsync edge is unchanged relative to hpos. vblank_start remains high across the ce=0 cycles, while frame_count increments once.
- Parameter override: 640x480 set (H_DISPLAY 640, H_FRONT 16, H_SYNC 96, H_BACK 48; V_DISPLAY 480, V_FRONT 10, V_SYNC 2, V_BACK 33) -> line period 800 cycles, frame period 420000 cycles, hsync low on hpos 656..751, vsync low on vpos 490..491.

Source files
------------

// File: rtl/vga_timing_core.sv
// Raster timing generator: pixel/line counters, registered sync and display-enable flags,
// line/frame strobes and a wrapping frame counter, all advancing only on ce.
module vga_timing_core #(
    parameter int H_DISPLAY  = 1024,
    parameter int H_FRONT    = 24,
    parameter int H_SYNC     = 136,
    parameter int H_BACK     = 160,
    parameter int V_DISPLAY  = 768,
    parameter int V_FRONT    = 3,
    parameter int V_SYNC     = 6,
    parameter int V_BACK     = 29,
    parameter int H_SYNC_POL = 0,
    parameter int V_SYNC_POL = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    output logic [10:0] hpos,
    output logic [9:0]  vpos,
    output logic        hsync,
    output logic        vsync,
    output logic        display_on,
    output logic        line_start,
    output logic        vblank_start,
    output logic [9:0]  frame_count
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > 2048 || V_TOTAL > 1024) begin : g_bad_timing
        $error("vga_timing_core: H_TOTAL must be <= 2048 and V_TOTAL <= 1024");
    end

    // Comparison constants are one bit wider than the counters so a sync window
    // ending exactly at the total count (2048 / 1024) still fits.
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [11:0] H_DISP_W = 12'(H_DISPLAY);
    localparam logic [11:0] HS_START = 12'(H_DISPLAY + H_FRONT);
    localparam logic [11:0] HS_END   = 12'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [10:0] V_DISP_W = 11'(V_DISPLAY);
    localparam logic [10:0] VS_START = 11'(V_DISPLAY + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic        H_ACT    = (H_SYNC_POL != 0);
    localparam logic        V_ACT    = (V_SYNC_POL != 0);

    logic [10:0] hpos_q, hpos_d;
    logic [9:0]  vpos_q, vpos_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        display_on_q, display_on_d;
    logic        line_start_q, line_start_d;
    logic        vblank_start_q, vblank_start_d;
    logic [9:0]  frame_count_q, frame_count_d;

    logic [11:0] h_ext;
    logic [10:0] v_ext;

    // Flags are decoded from the next counter value so they line up with the
    // coordinates presented in the same cycle.
    always_comb begin
        hpos_d = hpos_q + 11'd1;
        vpos_d = vpos_q;
        if (hpos_q == H_LAST) begin
            hpos_d = 11'd0;
            vpos_d = (vpos_q == V_LAST) ? 10'd0 : vpos_q + 10'd1;
        end

        h_ext = {1'b0, hpos_d};
        v_ext = {1'b0, vpos_d};

        hsync_d        = ((h_ext >= HS_START) && (h_ext < HS_END)) ? H_ACT : ~H_ACT;
        vsync_d        = ((v_ext >= VS_START) && (v_ext < VS_END)) ? V_ACT : ~V_ACT;
        display_on_d   = (h_ext < H_DISP_W) && (v_ext < V_DISP_W);
        line_start_d   = (hpos_d == 11'd0);
        vblank_start_d = (hpos_d == 11'd0) && (v_ext == V_DISP_W);
        frame_count_d  = vblank_start_d ? frame_count_q + 10'd1 : frame_count_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hpos_q         <= 11'd0;
            vpos_q         <= 10'd0;
            hsync_q        <= ~H_ACT;
            vsync_q        <= ~V_ACT;
            display_on_q   <= 1'b0;
            line_start_q   <= 1'b0;
            vblank_start_q <= 1'b0;
            frame_count_q  <= 10'd0;
        end else if (ce) begin
            hpos_q         <= hpos_d;
            vpos_q         <= vpos_d;
            hsync_q        <= hsync_d;
            vsync_q        <= vsync_d;
            display_on_q   <= display_on_d;
            line_start_q   <= line_start_d;
            vblank_start_q <= vblank_start_d;
            frame_count_q  <= frame_count_d;
        end
    end

    assign hpos         = hpos_q;
    assign vpos         = vpos_q;
    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign display_on   = display_on_q;
    assign line_start   = line_start_q;
    assign vblank_start = vblank_start_q;
    assign frame_count  = frame_count_q;

endmodule
